// File: rtl/dram_pkg.sv
// rtl/dram_pkg.sv - shared DRAM constants, command encoding and arbiter state type
package dram_pkg;

    localparam int DRAM_NUM_PORTS      = 4;
    localparam int DRAM_ADDR_WIDTH     = 10;
    localparam int DRAM_DATA_WIDTH     = 8;
    localparam int DRAM_TIMEOUT_CYCLES = 64;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    typedef enum logic [1:0] {
        S_ARB       = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_DATA = 2'd2
    } arb_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - combinational round-robin picker searching upward from ptr
module rr_priority_picker #(
    parameter int NUM_PORTS = 4,
    parameter int IDX_WIDTH = 2
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_WIDTH-1:0] ptr,
    output logic [NUM_PORTS-1:0] gnt,
    output logic [IDX_WIDTH-1:0] idx,
    output logic                 any
);

    always_comb begin
        logic [IDX_WIDTH-1:0] k;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        k   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            k = IDX_WIDTH'((int'(ptr) + i) % NUM_PORTS);
            if (!any && req[k]) begin
                any    = 1'b1;
                gnt[k] = 1'b1;
                idx    = k;
            end
        end
    end

endmodule

// File: rtl/dram_port_arbiter.sv
// rtl/dram_port_arbiter.sv - round-robin multi-port front end for a single DRAM controller
module dram_port_arbiter
    import dram_pkg::*;
#(
    parameter int NUM_PORTS      = DRAM_NUM_PORTS,
    parameter int U_ADDR_WIDTH   = DRAM_ADDR_WIDTH,
    parameter int U_DATA_WIDTH   = DRAM_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = DRAM_TIMEOUT_CYCLES
) (
    input  logic                              u_clk,
    input  logic                              u_rst,
    input  logic [NUM_PORTS-1:0]              p_req,
    input  logic [NUM_PORTS-1:0]              p_cmd,
    input  logic [NUM_PORTS*U_ADDR_WIDTH-1:0] p_addr,
    input  logic [NUM_PORTS*U_DATA_WIDTH-1:0] p_wdata,
    output logic [NUM_PORTS-1:0]              p_gnt,
    output logic [U_DATA_WIDTH-1:0]           p_rdata,
    output logic [NUM_PORTS-1:0]              p_rvalid,
    output logic [NUM_PORTS-1:0]              p_err,
    output logic                              c_en,
    output logic                              c_cmd,
    output logic [U_ADDR_WIDTH-1:0]           c_addr,
    output logic [U_DATA_WIDTH-1:0]           c_wdata,
    input  logic                              c_ack,
    input  logic                              c_busy,
    input  logic [U_DATA_WIDTH-1:0]           c_rdata,
    input  logic                              c_rvalid
);

    localparam int IW  = idx_width(NUM_PORTS);
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

    arb_state_t           state, state_next;
    logic [IW-1:0]        ptr;
    logic [NUM_PORTS-1:0] owner;
    logic [WDW-1:0]       wdog;
    logic [NUM_PORTS-1:0] pick_gnt;
    logic [IW-1:0]        pick_idx;
    logic                 pick_any;
    logic                 take, finish_rd, timeout, wdog_hit;

    rr_priority_picker #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_WIDTH (IW)
    ) u_picker (
        .req (p_req),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Hit is flagged on the last counted cycle so the error pulse lands TIMEOUT_CYCLES after entry.
    assign wdog_hit = (wdog == WDW'(TIMEOUT_CYCLES - 1));
    assign c_en     = (state == S_ISSUE);

    always_ff @(posedge u_clk) begin
        if (u_rst) begin
            state <= S_ARB;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        take       = 1'b0;
        finish_rd  = 1'b0;
        timeout    = 1'b0;
        case (state)
            S_ARB: begin
                if (!c_busy && pick_any) begin
                    take       = 1'b1;
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (c_ack) begin
                    if (c_cmd == CMD_WRITE) begin
                        state_next = S_ARB;
                    end else if (c_rvalid) begin
                        finish_rd  = 1'b1;
                        state_next = S_ARB;
                    end else begin
                        state_next = S_WAIT_DATA;
                    end
                end else if (wdog_hit) begin
                    timeout    = 1'b1;
                    state_next = S_ARB;
                end
            end
            S_WAIT_DATA: begin
                if (c_rvalid) begin
                    finish_rd  = 1'b1;
                    state_next = S_ARB;
                end else if (wdog_hit) begin
                    timeout    = 1'b1;
                    state_next = S_ARB;
                end
            end
            default: state_next = S_ARB;
        endcase
    end

    always_ff @(posedge u_clk) begin
        if (u_rst) begin
            ptr      <= '0;
            owner    <= '0;
            wdog     <= '0;
            p_gnt    <= '0;
            p_rvalid <= '0;
            p_err    <= '0;
            p_rdata  <= '0;
            c_cmd    <= CMD_READ;
            c_addr   <= '0;
            c_wdata  <= '0;
        end else begin
            p_gnt    <= take      ? pick_gnt : '0;
            p_rvalid <= finish_rd ? owner    : '0;
            p_err    <= timeout   ? owner    : '0;
            if (take) begin
                owner   <= pick_gnt;
                ptr     <= (int'(pick_idx) == NUM_PORTS - 1) ? '0 : pick_idx + IW'(1);
                c_cmd   <= p_cmd[pick_idx];
                c_addr  <= p_addr[int'(pick_idx)*U_ADDR_WIDTH +: U_ADDR_WIDTH];
                c_wdata <= p_wdata[int'(pick_idx)*U_DATA_WIDTH +: U_DATA_WIDTH];
            end
            if (finish_rd) begin
                p_rdata <= c_rdata;
            end
            if (state_next != state || state == S_ARB) begin
                wdog <= '0;
            end else begin
                wdog <= wdog + WDW'(1);
            end
        end
    end

endmodule

// File: tb/tb_dram_port_arbiter.sv
// tb/tb_dram_port_arbiter.sv - scoreboard bench for dram_port_arbiter
module tb_dram_port_arbiter;

    localparam int NP = 4;
    localparam int AW = 10;
    localparam int DW = 8;
    localparam int TO = 64;

    logic             u_clk = 1'b0;
    logic             u_rst;
    logic [NP-1:0]    p_req, p_cmd;
    logic [NP*AW-1:0] p_addr;
    logic [NP*DW-1:0] p_wdata;
    logic [NP-1:0]    p_gnt, p_rvalid, p_err;
    logic [DW-1:0]    p_rdata;
    logic             c_en, c_cmd;
    logic [AW-1:0]    c_addr;
    logic [DW-1:0]    c_wdata;
    logic             c_ack, c_busy, c_rvalid;
    logic [DW-1:0]    c_rdata;

    typedef struct {
        int          kind;
        int          port;
        logic [7:0]  data;
    } ev_t;

    typedef struct {
        int          port;
        logic        cmd;
        logic [9:0]  addr;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
        int          ack_dly;
        int          rv_dly;
    } txn_t;

    ev_t  sb[$];
    int   total = 0;
    int   bad   = 0;
    bit   mon_en = 1'b0;

    dram_port_arbiter #(
        .NUM_PORTS      (NP),
        .U_ADDR_WIDTH   (AW),
        .U_DATA_WIDTH   (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .u_clk    (u_clk),
        .u_rst    (u_rst),
        .p_req    (p_req),
        .p_cmd    (p_cmd),
        .p_addr   (p_addr),
        .p_wdata  (p_wdata),
        .p_gnt    (p_gnt),
        .p_rdata  (p_rdata),
        .p_rvalid (p_rvalid),
        .p_err    (p_err),
        .c_en     (c_en),
        .c_cmd    (c_cmd),
        .c_addr   (c_addr),
        .c_wdata  (c_wdata),
        .c_ack    (c_ack),
        .c_busy   (c_busy),
        .c_rdata  (c_rdata),
        .c_rvalid (c_rvalid)
    );

    always #5 u_clk = ~u_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic proc_ev(input int kind, input logic [NP-1:0] vec);
        ev_t e;
        if (vec != '0) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_event kind=%0d actual=%0h required=none", kind, vec);
            end else begin
                e = sb.pop_front();
                check("ev_kind", kind, e.kind);
                check("ev_port", 32'(vec), 32'(1) << e.port);
                if (kind == 1) check("ev_rdata", 32'(p_rdata), 32'(e.data));
            end
        end
    endtask

    always @(negedge u_clk) begin
        if (mon_en) begin
            check("onehot_gnt", 32'($onehot0(p_gnt)), 1);
            check("onehot_rvalid", 32'($onehot0(p_rvalid)), 1);
            check("onehot_err", 32'($onehot0(p_err)), 1);
            check("no_overlap", 32'((p_gnt & p_rvalid) | (p_gnt & p_err) | (p_rvalid & p_err)), 0);
            proc_ev(0, p_gnt);
            proc_ev(1, p_rvalid);
            proc_ev(2, p_err);
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_p_gnt"}, 32'(p_gnt), 0);
        check({tag, "_p_rvalid"}, 32'(p_rvalid), 0);
        check({tag, "_p_err"}, 32'(p_err), 0);
        check({tag, "_p_rdata"}, 32'(p_rdata), 0);
        check({tag, "_c_en"}, 32'(c_en), 0);
        check({tag, "_c_cmd"}, 32'(c_cmd), 0);
        check({tag, "_c_addr"}, 32'(c_addr), 0);
        check({tag, "_c_wdata"}, 32'(c_wdata), 0);
    endtask

    task automatic reset_dut();
        u_rst    = 1'b1;
        p_req    = '0;
        p_cmd    = '0;
        p_addr   = '0;
        p_wdata  = '0;
        c_ack    = 1'b0;
        c_busy   = 1'b0;
        c_rvalid = 1'b0;
        c_rdata  = '0;
        repeat (2) @(negedge u_clk);
        check_all_zero("reset");
        u_rst = 1'b0;
    endtask

    task automatic wait_gnt(output int n);
        n = 0;
        do begin
            @(negedge u_clk);
            n++;
        end while (p_gnt == '0 && n < 20);
    endtask

    task automatic do_txn(input txn_t t);
        int n;
        @(negedge u_clk);
        p_req[t.port]              = 1'b1;
        p_cmd[t.port]              = t.cmd;
        p_addr[t.port*AW +: AW]    = t.addr;
        p_wdata[t.port*DW +: DW]   = t.wdata;
        sb.push_back('{0, t.port, 8'h00});
        wait_gnt(n);
        check("gnt_latency", n, 1);
        check("gnt_port", 32'(p_gnt), 32'(1) << t.port);
        p_req[t.port] = 1'b0;
        check("c_en_at_gnt", 32'(c_en), 1);
        check("c_cmd", 32'(c_cmd), 32'(t.cmd));
        check("c_addr", 32'(c_addr), 32'(t.addr));
        check("c_wdata", 32'(c_wdata), 32'(t.wdata));
        for (int i = 0; i < t.ack_dly; i++) begin
            if (i == 0 && t.cmd == 1'b0) begin
                c_rvalid = 1'b1;
                c_rdata  = ~t.rdata;
            end
            @(negedge u_clk);
            c_rvalid = 1'b0;
            check("c_en_hold", 32'(c_en), 1);
            check("c_addr_hold", 32'(c_addr), 32'(t.addr));
        end
        c_ack = 1'b1;
        if (t.cmd == 1'b1) begin
            c_rvalid = 1'b1;
            c_rdata  = 8'hEE;
        end else if (t.rv_dly == 0) begin
            c_rvalid = 1'b1;
            c_rdata  = t.rdata;
            sb.push_back('{1, t.port, t.rdata});
        end
        @(negedge u_clk);
        c_ack    = 1'b0;
        c_rvalid = 1'b0;
        check("c_en_after_ack", 32'(c_en), 0);
        if (t.cmd == 1'b0 && t.rv_dly > 0) begin
            repeat (t.rv_dly - 1) @(negedge u_clk);
            c_rvalid = 1'b1;
            c_rdata  = t.rdata;
            sb.push_back('{1, t.port, t.rdata});
            @(negedge u_clk);
            c_rvalid = 1'b0;
        end
        repeat (2) @(negedge u_clk);
    endtask

    initial begin
        txn_t tbl[5];
        int   n;
        tbl[0] = '{0, 1'b1, 10'h155, 8'hA5, 8'h00, 2, 0};
        tbl[1] = '{2, 1'b0, 10'h2A0, 8'h00, 8'h3C, 0, 5};
        tbl[2] = '{1, 1'b0, 10'h0FF, 8'h11, 8'hC3, 1, 0};
        tbl[3] = '{3, 1'b1, 10'h3FF, 8'h5A, 8'h00, 0, 0};
        tbl[4] = '{3, 1'b0, 10'h001, 8'h22, 8'h81, 3, 2};

        reset_dut();
        mon_en = 1'b1;
        for (int i = 0; i < 5; i++) do_txn(tbl[i]);

        // c_rvalid while idle must not surface
        c_rvalid = 1'b1;
        c_rdata  = 8'h77;
        @(negedge u_clk);
        c_rvalid = 1'b0;
        repeat (2) @(negedge u_clk);

        // fairness: all ports request continuously
        reset_dut();
        p_cmd = 4'hF;
        for (int k = 0; k < NP; k++) p_addr[k*AW +: AW] = AW'(10'h100 + k);
        p_req = 4'hF;
        for (int i = 0; i < 5; i++) sb.push_back('{0, i % NP, 8'h00});
        for (int i = 0; i < 5; i++) begin
            wait_gnt(n);
            check("fair_order", 32'(p_gnt), 32'(1) << (i % NP));
            check("fair_addr", 32'(c_addr), 32'(10'h100 + (i % NP)));
            if (i == 4) p_req = '0;
            @(negedge u_clk);
            c_ack = 1'b1;
            @(negedge u_clk);
            c_ack = 1'b0;
        end
        repeat (3) @(negedge u_clk);

        // busy hold
        reset_dut();
        c_busy   = 1'b1;
        p_cmd[1] = 1'b1;
        p_req    = 4'b0010;
        sb.push_back('{0, 1, 8'h00});
        for (int i = 0; i < 10; i++) begin
            @(negedge u_clk);
            check("busy_no_gnt", 32'(p_gnt), 0);
        end
        c_busy = 1'b0;
        @(negedge u_clk);
        check("busy_release_gnt", 32'(p_gnt), 32'b0010);
        p_req = '0;
        c_ack = 1'b1;
        @(negedge u_clk);
        c_ack = 1'b0;
        repeat (2) @(negedge u_clk);

        // watchdog timeout on a read that never returns data
        reset_dut();
        p_cmd = 4'b1000;
        p_req = 4'b1001;
        sb.push_back('{0, 0, 8'h00});
        wait_gnt(n);
        check("to_first_gnt", 32'(p_gnt), 32'b0001);
        p_req[0] = 1'b0;
        c_ack    = 1'b1;
        sb.push_back('{2, 0, 8'h00});
        sb.push_back('{0, 3, 8'h00});
        @(negedge u_clk);
        c_ack = 1'b0;
        check("to_wait_c_en", 32'(c_en), 0);
        n = 0;
        do begin
            @(negedge u_clk);
            n++;
        end while (p_err == '0 && n < 100);
        check("to_err_delay", n, TO);
        check("to_err_port", 32'(p_err), 32'b0001);
        check("to_err_c_en", 32'(c_en), 0);
        @(negedge u_clk);
        check("to_next_gnt", 32'(p_gnt), 32'b1000);
        p_req = '0;
        c_ack = 1'b1;
        @(negedge u_clk);
        c_ack = 1'b0;
        repeat (2) @(negedge u_clk);

        // reset while waiting for read data
        reset_dut();
        p_cmd = '0;
        p_req = 4'b0010;
        sb.push_back('{0, 1, 8'h00});
        wait_gnt(n);
        check("rst_mid_gnt", 32'(p_gnt), 32'b0010);
        p_req = '0;
        c_ack = 1'b1;
        @(negedge u_clk);
        c_ack = 1'b0;
        repeat (3) @(negedge u_clk);
        u_rst = 1'b1;
        @(negedge u_clk);
        check_all_zero("rst_mid");
        u_rst = 1'b0;
        repeat (2) @(negedge u_clk);
        c_rvalid = 1'b1;
        c_rdata  = 8'h99;
        @(negedge u_clk);
        c_rvalid = 1'b0;
        repeat (3) @(negedge u_clk);
        check("rst_mid_late_c_en", 32'(c_en), 0);

        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dram_port_arbiter.md
DRAM_PORT_ARBITER -- requirements
Module: dram_port_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4: number of requesters; legal range 2..8.
REQ-002 SHALL have parameter U_ADDR_WIDTH, default 10: host address width (bank+row+column).
REQ-003 SHALL have parameter U_DATA_WIDTH, default 8: host data width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 64: watchdog limit while waiting on the controller.
REQ-005 SHALL use one clock and a synchronous, active-high reset, named as the codebase does:
- u_clk  in  1  sole clock; all state changes on its rising edge.
- u_rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have the following requester-side ports:
- p_req  in  NUM_PORTS  per-port request, held until granted.
- p_cmd  in  NUM_PORTS  per-port command: 1 = write, 0 = read.
- p_addr  in  NUM_PORTS*U_ADDR_WIDTH  packed per-port address; port k occupies slice k.
- p_wdata  in  NUM_PORTS*U_DATA_WIDTH  packed per-port write data.
- p_gnt  out  NUM_PORTS  one-hot, 1-cycle accept pulse.
- p_rdata  out  U_DATA_WIDTH  read data, valid with p_rvalid.
- p_rvalid  out  NUM_PORTS  one-hot, 1-cycle read-return pulse.
- p_err  out  NUM_PORTS  one-hot, 1-cycle timeout pulse.
REQ-007 SHALL have the following controller-side ports:
- c_en  out  1  command-valid level to the controller.
- c_cmd  out  1  command to the controller: 1 = write.
- c_addr  out  U_ADDR_WIDTH  address to the controller.
- c_wdata  out  U_DATA_WIDTH  write data to the controller.
- c_ack  in  1  command accepted.
- c_busy  in  1  controller cannot take a new command.
- c_rdata  in  U_DATA_WIDTH  read data from the controller.
- c_rvalid  in  1  read data valid.

Function
REQ-008 SHALL implement the FSM S_ARB, S_ISSUE, S_WAIT_DATA.
REQ-009 In S_ARB with c_busy=0 and p_req!=0, SHALL select the winner by round-robin from pointer ptr upward, modulo NUM_PORTS.
REQ-010 On selection, SHALL latch the winner's index, p_cmd, p_addr slice and p_wdata slice; SHALL pulse p_gnt[winner] on the next cycle; SHALL enter S_ISSUE.
REQ-011 In S_ARB with c_busy=1, SHALL grant nothing and SHALL hold all state.
REQ-012 In S_ISSUE, SHALL drive c_en=1 and the latched c_cmd/c_addr/c_wdata, starting the same cycle p_gnt is high and holding them until c_ack=1.
REQ-013 On c_ack with a write, SHALL return to S_ARB next cycle.
REQ-014 On c_ack with a read and c_rvalid=0, SHALL enter S_WAIT_DATA.
REQ-015 On c_ack with a read and c_rvalid=1 in the same cycle, SHALL complete as in REQ-016 and return to S_ARB.
REQ-016 On c_rvalid in S_WAIT_DATA, SHALL register p_rdata=c_rdata and pulse p_rvalid[owner] the following cycle, then return to S_ARB.
REQ-017 SHALL ignore c_rvalid in S_ARB and in S_ISSUE before c_ack, and on write transactions; such events produce no p_rvalid.
REQ-018 SHALL set ptr=(winner+1) mod NUM_PORTS at grant time.
REQ-019 SHALL never grant a second request while a transaction is outstanding; at most one transaction is open at any time.
REQ-020 SHALL take round-trip latency, req-to-c_en, of 1 cycle when idle and c_busy=0.
REQ-021 SHALL run a watchdog counter in S_ISSUE and S_WAIT_DATA, cleared on every state entry.
REQ-022 When the watchdog reaches TIMEOUT_CYCLES, SHALL pulse p_err[owner] for 1 cycle, drop c_en, return to S_ARB and advance ptr normally.
REQ-023 A requester dropping p_req before grant SHALL NOT be granted; p_req level outside S_ARB SHALL be ignored.
REQ-024 p_gnt, p_rvalid and p_err SHALL each be one-hot or zero, and SHALL never overlap for the same port in the same cycle.

Reset
REQ-025 On u_rst=1 at a clock edge, SHALL enter S_ARB with ptr=0 and watchdog=0.
REQ-026 On reset, SHALL drive p_gnt=0, p_rvalid=0, p_err=0, p_rdata=0, c_en=0, c_cmd=0, c_addr=0 and c_wdata=0.
REQ-027 Reset mid-transaction SHALL abandon the transaction silently: no p_rvalid and no p_err for it.

Structure
REQ-028 Shared package dram_pkg SHALL hold the arbiter state encoding, CMD_READ=0/CMD_WRITE=1 and the default width constants shared with the DRAM controller.
REQ-029 Round-robin selection SHALL be a combinational sub-module rr_priority_picker (inputs: req vector, ptr; outputs: one-hot grant, index, any).

Verification
REQ-030 Bench SHALL cover single write: reset, p_req=0001 with write addr 0x155 data 0xA5 -> p_gnt=0001 next cycle, c_en=1 with c_addr=0x155 and c_wdata=0xA5 until c_ack, no p_rvalid.
REQ-031 Bench SHALL cover fairness: p_req=1111 held continuously, controller acks each command in 2 cycles -> grants in order 0,1,2,3,0.
REQ-032 Bench SHALL cover read return: port 2 reads, c_rvalid arrives 5 cycles after c_ack with c_rdata=0x3C -> p_rvalid=0100 and p_rdata=0x3C exactly once.
REQ-033 Bench SHALL cover busy hold: c_busy=1 for 10 cycles with p_req=0010 -> no p_gnt; grant occurs 1 cycle after c_busy falls.
REQ-034 Bench SHALL cover timeout: read with c_rvalid never asserted, TIMEOUT_CYCLES=64 -> p_err pulses for the owner 64 cycles after S_WAIT_DATA entry, then the next pending port is granted.
REQ-035 Bench SHALL cover reset mid-read: u_rst asserted in S_WAIT_DATA -> all outputs 0 next cycle; a late c_rvalid produces no p_rvalid.
